tmds_decoder: RTL

Receive-side TMDS channel decoder for the video subsystem. It takes one 10-bit parallel TMDS symbol per clock from the channel deserializer and recovers 8-bit video data, 2-bit control data and the data-enable flag, exactly inverting the transmit encoding. It also finds word alignment: a hunt/lock state machine that counts control tokens, requests bit-slips from the deserializer, and reports lock. One instance per colour channel.

---
 rtl/tmds_pkg.sv | 24 ++
 rtl/tmds_symbol_decode.sv | 42 ++++
 rtl/tmds_decoder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens (common with the transmit encoder),
// alignment FSM states and counter sizing helper.
package tmds_pkg;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } tmds_state_e;

    // Width holding the largest of the three timing parameters without wrap.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol classifier: detects control tokens and undoes
// the transition-minimising data encoding.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] tmds_i,
    output logic       is_ctrl,
    output logic [1:0] cd,
    output logic [7:0] vd
);

    logic [7:0] d_s;

    assign d_s = tmds_i[9] ? ~tmds_i[7:0] : tmds_i[7:0];

    // Control token lookup; anything else is treated as data.
    always_comb begin
        is_ctrl = 1'b0;
        cd      = 2'b00;
        case (tmds_i)
            CTRL_TOKEN_00: begin is_ctrl = 1'b1; cd = 2'b00; end
            CTRL_TOKEN_01: begin is_ctrl = 1'b1; cd = 2'b01; end
            CTRL_TOKEN_10: begin is_ctrl = 1'b1; cd = 2'b10; end
            CTRL_TOKEN_11: begin is_ctrl = 1'b1; cd = 2'b11; end
            default:       begin is_ctrl = 1'b0; cd = 2'b00; end
        endcase
    end

    // Bit 8 selects whether the encoder chained XOR or XNOR.
    always_comb begin
        vd    = 8'h00;
        vd[0] = d_s[0];
        for (int i = 1; i < 8; i++) begin
            if (tmds_i[8]) begin
                vd[i] = d_s[i] ^ d_s[i-1];
            end else begin
                vd[i] = ~(d_s[i] ^ d_s[i-1]);
            end
        end
    end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder with word-alignment hunt/lock FSM driving the
// deserializer bit-slip request.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_RUN      = 8,
    parameter int SEARCH_WINDOW = 2048,
    parameter int SLIP_SETTLE   = 16
) (
    input  logic       clk,
    input  logic       rstn_i,
    input  logic [9:0] tmds_i,
    output logic [7:0] vd_o,
    output logic [1:0] cd_o,
    output logic       vde_o,
    output logic       locked_o,
    output logic       bitslip_o
);

    localparam int CNT_W = cnt_width(LOCK_RUN, SEARCH_WINDOW, SLIP_SETTLE);

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] RUN_MAX     = CNT_W'(LOCK_RUN);
    localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(SEARCH_WINDOW - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SLIP_SETTLE - 1);

    tmds_state_e      state_r, state_nxt_s;
    logic [CNT_W-1:0] run_r, run_nxt_s, run_inc_s;
    logic [CNT_W-1:0] win_r, win_nxt_s;
    logic [CNT_W-1:0] settle_r, settle_nxt_s;

    logic [7:0] vd_r, vd_nxt_s;
    logic [1:0] cd_r, cd_nxt_s;
    logic       vde_r, vde_nxt_s;
    logic       locked_r, locked_nxt_s;
    logic       bitslip_r, bitslip_nxt_s;

    logic       is_ctrl_s;
    logic [1:0] cd_s;
    logic [7:0] vd_s;

    tmds_symbol_decode u_symbol_decode (
        .tmds_i  (tmds_i),
        .is_ctrl (is_ctrl_s),
        .cd      (cd_s),
        .vd      (vd_s)
    );

    // Saturating increment of the consecutive-token run.
    always_comb begin
        if (run_r >= RUN_MAX) begin
            run_inc_s = RUN_MAX;
        end else begin
            run_inc_s = run_r + CNT_ONE;
        end
    end

    // Alignment FSM, counters and next output values.
    always_comb begin
        state_nxt_s   = state_r;
        run_nxt_s     = run_r;
        win_nxt_s     = win_r;
        settle_nxt_s  = settle_r;
        vd_nxt_s      = vd_r;
        cd_nxt_s      = cd_r;
        vde_nxt_s     = vde_r;
        locked_nxt_s  = locked_r;
        bitslip_nxt_s = 1'b0;

        case (state_r)
            SEARCH: begin
                vde_nxt_s = 1'b0;
                if (is_ctrl_s) begin
                    // A token on the expiry cycle takes priority over slipping.
                    cd_nxt_s  = cd_s;
                    win_nxt_s = CNT_ZERO;
                    run_nxt_s = run_inc_s;
                    if (run_inc_s >= RUN_MAX) begin
                        state_nxt_s  = LOCKED;
                        locked_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s  = SEARCH;
                        locked_nxt_s = 1'b0;
                    end
                end else begin
                    vd_nxt_s  = vd_s;
                    run_nxt_s = CNT_ZERO;
                    if (win_r >= WIN_LAST) begin
                        state_nxt_s   = SETTLE;
                        bitslip_nxt_s = 1'b1;
                        win_nxt_s     = CNT_ZERO;
                        settle_nxt_s  = CNT_ZERO;
                    end else begin
                        win_nxt_s = win_r + CNT_ONE;
                    end
                end
            end

            SETTLE: begin
                // Deserializer is realigning; symbols here are meaningless.
                if (settle_r >= SETTLE_LAST) begin
                    state_nxt_s  = SEARCH;
                    settle_nxt_s = CNT_ZERO;
                    run_nxt_s    = CNT_ZERO;
                    win_nxt_s    = CNT_ZERO;
                end else begin
                    settle_nxt_s = settle_r + CNT_ONE;
                end
            end

            LOCKED: begin
                if (is_ctrl_s) begin
                    cd_nxt_s  = cd_s;
                    vde_nxt_s = 1'b0;
                    win_nxt_s = CNT_ZERO;
                    run_nxt_s = run_inc_s;
                end else begin
                    vd_nxt_s  = vd_s;
                    run_nxt_s = CNT_ZERO;
                    if (win_r >= WIN_LAST) begin
                        // Lock lost: hunt again without slipping first.
                        state_nxt_s  = SEARCH;
                        locked_nxt_s = 1'b0;
                        vde_nxt_s    = 1'b0;
                        win_nxt_s    = CNT_ZERO;
                    end else begin
                        vde_nxt_s = 1'b1;
                        win_nxt_s = win_r + CNT_ONE;
                    end
                end
            end

            default: begin
                state_nxt_s  = SEARCH;
                run_nxt_s    = CNT_ZERO;
                win_nxt_s    = CNT_ZERO;
                settle_nxt_s = CNT_ZERO;
                vde_nxt_s    = 1'b0;
                locked_nxt_s = 1'b0;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r   <= SEARCH;
            run_r     <= CNT_ZERO;
            win_r     <= CNT_ZERO;
            settle_r  <= CNT_ZERO;
            vd_r      <= 8'h00;
            cd_r      <= 2'b00;
            vde_r     <= 1'b0;
            locked_r  <= 1'b0;
            bitslip_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            run_r     <= run_nxt_s;
            win_r     <= win_nxt_s;
            settle_r  <= settle_nxt_s;
            vd_r      <= vd_nxt_s;
            cd_r      <= cd_nxt_s;
            vde_r     <= vde_nxt_s;
            locked_r  <= locked_nxt_s;
            bitslip_r <= bitslip_nxt_s;
        end
    end

    assign vd_o      = vd_r;
    assign cd_o      = cd_r;
    assign vde_o     = vde_r;
    assign locked_o  = locked_r;
    assign bitslip_o = bitslip_r;

endmodule
